multicycle_control: RTL

- Multi-cycle control FSM for the 16-bit CPU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables from the latched opcode.
- Generalises the single-cycle opcode decoder:
  - parametrised opcode width;
  - memory-ready handshake with stalls;
  - halt and illegal-opcode trapping;
  - instruction-retire pulse.
- Sits between instruction register/memory interface and register file/ALU/PC.

---
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : FETCH/DECODE/EXEC/MEM/WB sequencer that drives the 16-bit CPU
//            datapath enables. Optional stall counter under STALL_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                reg_dst,
    output logic                branch,
    output logic                beq,
    output logic                jump,
    output logic                mem_to_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src,
    output logic                reg_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                retire,
    output logic                halted,
    output logic                illegal,
    output logic [2:0]          state
`ifdef STALL_CNT_EN
   ,output logic [CNT_W-1:0]    stall_count
`endif
);

    typedef enum logic [2:0] {
        c_IDLE   = 3'd0,
        c_FETCH  = 3'd1,
        c_DECODE = 3'd2,
        c_EXEC   = 3'd3,
        c_MEM    = 3'd4,
        c_WB     = 3'd5,
        c_HALTED = 3'd6
    } state_t;

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_OR   = 4'h3;
    localparam logic [3:0] c_OP_ADDI = 4'h4;
    localparam logic [3:0] c_OP_LW   = 4'h5;
    localparam logic [3:0] c_OP_SW   = 4'h6;
    localparam logic [3:0] c_OP_BEQ  = 4'h7;
    localparam logic [3:0] c_OP_BNE  = 4'h8;
    localparam logic [3:0] c_OP_JMP  = 4'h9;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    if (OPCODE_W < 4 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control: OPCODE_W must be >= 4 and CNT_W >= 1");
    end

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_op_q;
    logic       r_illegal;
    logic       w_set_illegal;
    logic [3:0] w_op_lo;
    logic       w_op_legal;

    // Only legal opcodes ever reach EXEC, so the latch keeps just the low nibble.
    assign w_op_lo    = opcode[3:0];
    assign w_op_legal = ((opcode >> 4) == {OPCODE_W{1'b0}}) &&
                        !((w_op_lo >= 4'hA) && (w_op_lo <= 4'hE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_op_q    <= 4'h0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_DECODE) begin
                r_op_q <= w_op_lo;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        reg_dst       = 1'b0;
        branch        = 1'b0;
        beq           = 1'b0;
        jump          = 1'b0;
        mem_to_reg    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        illegal       = r_illegal;
        state         = r_state;

        case (r_state)
            c_IDLE: w_next_state = c_FETCH;
            c_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = c_DECODE;
                end
            end
            c_DECODE: begin
                if (!w_op_legal) begin
                    w_next_state  = c_HALTED;
                    w_set_illegal = 1'b1;
                end else if (w_op_lo == c_OP_HALT) begin
                    w_next_state = c_HALTED;
                end else if (w_op_lo == c_OP_JMP) begin
                    jump         = 1'b1;
                    retire       = 1'b1;
                    w_next_state = c_FETCH;
                end else begin
                    w_next_state = c_EXEC;
                end
            end
            c_EXEC: begin
                case (r_op_q)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: w_next_state = c_WB;
                    c_OP_ADDI: begin
                        alu_src      = 1'b1;
                        w_next_state = c_WB;
                    end
                    c_OP_LW, c_OP_SW: begin
                        alu_src      = 1'b1;
                        w_next_state = c_MEM;
                    end
                    c_OP_BEQ, c_OP_BNE: begin
                        branch       = 1'b1;
                        beq          = (r_op_q == c_OP_BEQ);
                        retire       = 1'b1;
                        w_next_state = c_FETCH;
                    end
                    default: w_next_state = c_FETCH;
                endcase
            end
            c_MEM: begin
                mem_read  = (r_op_q == c_OP_LW);
                mem_write = (r_op_q != c_OP_LW);
                if (mem_ready) begin
                    if (r_op_q == c_OP_LW) begin
                        w_next_state = c_WB;
                    end else begin
                        retire       = 1'b1;
                        w_next_state = c_FETCH;
                    end
                end
            end
            c_WB: begin
                reg_write    = 1'b1;
                reg_dst      = (r_op_q <= c_OP_OR);
                mem_to_reg   = (r_op_q == c_OP_LW);
                alu_src      = (r_op_q == c_OP_ADDI);
                retire       = 1'b1;
                w_next_state = c_FETCH;
            end
            c_HALTED: halted = 1'b1;
            default: w_next_state = c_IDLE;
        endcase

        // Reset silences the datapath immediately, even mid-instruction.
        if (rst) begin
            reg_dst    = 1'b0;
            branch     = 1'b0;
            beq        = 1'b0;
            jump       = 1'b0;
            mem_to_reg = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            alu_src    = 1'b0;
            reg_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            retire     = 1'b0;
            halted     = 1'b0;
            illegal    = 1'b0;
            state      = 3'd0;
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_count;
    logic             w_stall;

    assign w_stall = ((r_state == c_FETCH) || (r_state == c_MEM)) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = rst ? '0 : r_stall_count;
`endif

endmodule
`default_nettype wire
